// File: rtl/sram_dual_req_sched.sv
// Maps two requesters onto a 1RW+1R SRAM macro: port 0 takes writes (or r0's read when
// both requesters read), port 1 takes reads; hazards and write contention go round-robin.
module sram_dual_req_sched #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_req_valid,
  output logic                  r0_req_ready,
  input  logic                  r0_req_we,
  input  logic [ADDR_WIDTH-1:0] r0_req_addr,
  input  logic [DATA_WIDTH-1:0] r0_req_wdata,
  output logic                  r0_rsp_valid,
  output logic [DATA_WIDTH-1:0] r0_rsp_rdata,
  input  logic                  r1_req_valid,
  output logic                  r1_req_ready,
  input  logic                  r1_req_we,
  input  logic [ADDR_WIDTH-1:0] r1_req_addr,
  input  logic [DATA_WIDTH-1:0] r1_req_wdata,
  output logic                  r1_rsp_valid,
  output logic [DATA_WIDTH-1:0] r1_rsp_rdata,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0,
  output logic                  mem_csb1,
  output logic [ADDR_WIDTH-1:0] mem_addr1,
  input  logic [DATA_WIDTH-1:0] mem_dout1
);

  logic rr_ptr_q, rr_ptr_d;
  logic p0_tag_vld_q, p0_tag_vld_d;
  logic p1_tag_vld_q, p1_tag_vld_d;
  logic p1_tag_id_q, p1_tag_id_d;
  logic r0_rsp_valid_q, r0_rsp_valid_d;
  logic r1_rsp_valid_q, r1_rsp_valid_d;
  logic [DATA_WIDTH-1:0] r0_rsp_rdata_q, r0_rsp_rdata_d;
  logic [DATA_WIDTH-1:0] r1_rsp_rdata_q, r1_rsp_rdata_d;

  logic conflict, grant0, grant1;
  logic r0_hit0, r0_hit1, r1_hit1;

  // A conflict is two writes, or a write and read to the same word; only rr_ptr wins.
  always_comb begin
    conflict = r0_req_valid && r1_req_valid &&
               ((r0_req_we && r1_req_we) ||
                ((r0_req_we != r1_req_we) && (r0_req_addr == r1_req_addr)));
    grant0 = rst_n && r0_req_valid && (!conflict || !rr_ptr_q);
    grant1 = rst_n && r1_req_valid && (!conflict || rr_ptr_q);
    rr_ptr_d = conflict ? !rr_ptr_q : rr_ptr_q;
  end

  assign r0_req_ready = grant0;
  assign r1_req_ready = grant1;

  always_comb begin
    mem_csb0     = 1'b1;
    mem_web0     = 1'b1;
    mem_addr0    = '0;
    mem_din0     = '0;
    mem_csb1     = 1'b1;
    mem_addr1    = '0;
    p0_tag_vld_d = 1'b0;
    p1_tag_vld_d = 1'b0;
    p1_tag_id_d  = 1'b0;

    if (grant0 && r0_req_we) begin
      mem_csb0  = 1'b0;
      mem_web0  = 1'b0;
      mem_addr0 = r0_req_addr;
      mem_din0  = r0_req_wdata;
    end else if (grant1 && r1_req_we) begin
      mem_csb0  = 1'b0;
      mem_web0  = 1'b0;
      mem_addr0 = r1_req_addr;
      mem_din0  = r1_req_wdata;
    end else if (grant0 && grant1 && !r0_req_we && !r1_req_we) begin
      mem_csb0     = 1'b0;
      mem_addr0    = r0_req_addr;
      p0_tag_vld_d = 1'b1;
    end

    // Port 1 serves r1's read first; r0 only lands here when it is the lone reader.
    if (grant1 && !r1_req_we) begin
      mem_csb1     = 1'b0;
      mem_addr1    = r1_req_addr;
      p1_tag_vld_d = 1'b1;
      p1_tag_id_d  = 1'b1;
    end else if (grant0 && !r0_req_we) begin
      mem_csb1     = 1'b0;
      mem_addr1    = r0_req_addr;
      p1_tag_vld_d = 1'b1;
    end
  end

  always_comb begin
    r0_hit0 = p0_tag_vld_q;
    r0_hit1 = p1_tag_vld_q && !p1_tag_id_q;
    r1_hit1 = p1_tag_vld_q && p1_tag_id_q;
    r0_rsp_valid_d = r0_hit0 || r0_hit1;
    r1_rsp_valid_d = r1_hit1;
    r0_rsp_rdata_d = r0_rsp_rdata_q;
    r1_rsp_rdata_d = r1_rsp_rdata_q;
    if (r0_hit0)
      r0_rsp_rdata_d = mem_dout0;
    else if (r0_hit1)
      r0_rsp_rdata_d = mem_dout1;
    if (r1_hit1)
      r1_rsp_rdata_d = mem_dout1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= 1'b0;
      p0_tag_vld_q   <= 1'b0;
      p1_tag_vld_q   <= 1'b0;
      p1_tag_id_q    <= 1'b0;
      r0_rsp_valid_q <= 1'b0;
      r1_rsp_valid_q <= 1'b0;
      r0_rsp_rdata_q <= '0;
      r1_rsp_rdata_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      p0_tag_vld_q   <= p0_tag_vld_d;
      p1_tag_vld_q   <= p1_tag_vld_d;
      p1_tag_id_q    <= p1_tag_id_d;
      r0_rsp_valid_q <= r0_rsp_valid_d;
      r1_rsp_valid_q <= r1_rsp_valid_d;
      r0_rsp_rdata_q <= r0_rsp_rdata_d;
      r1_rsp_rdata_q <= r1_rsp_rdata_d;
    end
  end

  assign r0_rsp_valid = r0_rsp_valid_q;
  assign r1_rsp_valid = r1_rsp_valid_q;
  assign r0_rsp_rdata = r0_rsp_rdata_q;
  assign r1_rsp_rdata = r1_rsp_rdata_q;

endmodule

// File: tb/tb_sram_dual_req_sched.sv
// Directed bench for sram_dual_req_sched with a behavioural 1RW+1R macro model
// (inputs sampled on posedge, access performed on the following negedge).
module tb_sram_dual_req_sched;

  logic        clk;
  logic        rst_n;
  logic        r0_req_valid, r0_req_ready, r0_req_we, r0_rsp_valid;
  logic [9:0]  r0_req_addr;
  logic [31:0] r0_req_wdata, r0_rsp_rdata;
  logic        r1_req_valid, r1_req_ready, r1_req_we, r1_rsp_valid;
  logic [9:0]  r1_req_addr;
  logic [31:0] r1_req_wdata, r1_rsp_rdata;
  logic        mem_csb0, mem_web0, mem_csb1;
  logic [9:0]  mem_addr0, mem_addr1;
  logic [31:0] mem_din0, mem_dout0, mem_dout1;

  int checks = 0;
  int errors = 0;

  sram_dual_req_sched #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_we(r0_req_we),
    .r0_req_addr(r0_req_addr), .r0_req_wdata(r0_req_wdata),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_we(r1_req_we),
    .r1_req_addr(r1_req_addr), .r1_req_wdata(r1_req_wdata),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
    .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0),
    .mem_din0(mem_din0), .mem_dout0(mem_dout0),
    .mem_csb1(mem_csb1), .mem_addr1(mem_addr1), .mem_dout1(mem_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: latch controls at posedge, perform the access at the next negedge.
  logic [31:0] mem [0:1023];
  logic        s_csb0, s_web0, s_csb1;
  logic [9:0]  s_addr0, s_addr1;
  logic [31:0] s_din0;
  int          writeCount = 0;

  always @(posedge clk) begin
    s_csb0  <= mem_csb0;
    s_web0  <= mem_web0;
    s_addr0 <= mem_addr0;
    s_din0  <= mem_din0;
    s_csb1  <= mem_csb1;
    s_addr1 <= mem_addr1;
  end

  always @(negedge clk) begin
    if (!s_csb1) mem_dout1 = mem[s_addr1];
    if (!s_csb0 && s_web0) mem_dout0 = mem[s_addr0];
    if (!s_csb0 && !s_web0) begin
      mem[s_addr0] = s_din0;
      writeCount = writeCount + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    r0_req_valid = 0; r0_req_we = 0; r0_req_addr = '0; r0_req_wdata = '0;
    r1_req_valid = 0; r1_req_we = 0; r1_req_addr = '0; r1_req_wdata = '0;
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic dutWrite(input logic [9:0] a, input logic [31:0] d);
    r0_req_valid = 1; r0_req_we = 1; r0_req_addr = a; r0_req_wdata = d;
    tick();
    r0_req_valid = 0; r0_req_we = 0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 0;
    r0_req_valid = 1; r1_req_valid = 1; r1_req_we = 1; r1_req_wdata = 32'h1234_5678;
    #2;
    checks++;
    if ({r0_req_ready, r1_req_ready} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_ready: got %b want 00", {r0_req_ready, r1_req_ready});
    end
    checks++;
    if ({mem_csb0, mem_web0, mem_csb1} !== 3'b111) begin
      errors++; $display("[TB] FAIL reset_csb: got %b want 111", {mem_csb0, mem_web0, mem_csb1});
    end
    checks++;
    if ({mem_addr0, mem_addr1, mem_din0} !== 52'd0) begin
      errors++; $display("[TB] FAIL reset_addr_din: addr0=%h addr1=%h din0=%h want 0", mem_addr0, mem_addr1, mem_din0);
    end
    checks++;
    if ({r0_rsp_valid, r1_rsp_valid, r0_rsp_rdata, r1_rsp_rdata} !== 66'd0) begin
      errors++; $display("[TB] FAIL reset_rsp: v=%b%b d0=%h d1=%h want 0", r0_rsp_valid, r1_rsp_valid, r0_rsp_rdata, r1_rsp_rdata);
    end
    idleInputs();
    tick();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      #2;
      checks++;
      if ({mem_csb0, mem_csb1, mem_web0, r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid} !== 7'b1110000) begin
        errors++;
        $display("[TB] FAIL idle_cycle%0d: got %b want 1110000", i,
                 {mem_csb0, mem_csb1, mem_web0, r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid});
      end
    end
    tick();
  endtask

  task automatic test_write_read();
    r0_req_valid = 1; r0_req_we = 1; r0_req_addr = 10'h005; r0_req_wdata = 32'hDEADBEEF;
    #2;
    checks++;
    if ({r0_req_ready, mem_csb0, mem_web0, mem_csb1, mem_addr0, mem_din0} !== {4'b1001, 10'h005, 32'hDEADBEEF}) begin
      errors++; $display("[TB] FAIL wr_cycle0: rdy=%b csb0=%b web0=%b csb1=%b addr0=%h din0=%h want 1 0 0 1 005 deadbeef",
                         r0_req_ready, mem_csb0, mem_web0, mem_csb1, mem_addr0, mem_din0);
    end
    tick();
    r0_req_we = 0;
    #2;
    checks++;
    if ({r0_req_ready, mem_csb0, mem_csb1, mem_addr1} !== {3'b110, 10'h005}) begin
      errors++; $display("[TB] FAIL rd_cycle1: rdy=%b csb0=%b csb1=%b addr1=%h want 1 1 0 005",
                         r0_req_ready, mem_csb0, mem_csb1, mem_addr1);
    end
    tick();
    r0_req_valid = 0;
    #2;
    checks++;
    if (r0_rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_early: rsp_valid=%b want 0", r0_rsp_valid);
    end
    tick();
    #2;
    checks++;
    if ({r0_rsp_valid, r0_rsp_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("[TB] FAIL rd_after_wr: valid=%b data=%h want 1 deadbeef", r0_rsp_valid, r0_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_two_reads();
    dutWrite(10'h010, 32'h11);
    dutWrite(10'h020, 32'h22);
    r0_req_valid = 1; r0_req_addr = 10'h010;
    r1_req_valid = 1; r1_req_addr = 10'h020;
    #2;
    checks++;
    if ({r0_req_ready, r1_req_ready, mem_csb0, mem_web0, mem_csb1, mem_addr0, mem_addr1} !==
        {5'b11010, 10'h010, 10'h020}) begin
      errors++; $display("[TB] FAIL dual_read_ports: rdy=%b%b csb0=%b web0=%b csb1=%b a0=%h a1=%h want 11 0 1 0 010 020",
                         r0_req_ready, r1_req_ready, mem_csb0, mem_web0, mem_csb1, mem_addr0, mem_addr1);
    end
    tick();
    idleInputs();
    tick();
    #2;
    checks++;
    if ({r0_rsp_valid, r0_rsp_rdata, r1_rsp_valid, r1_rsp_rdata} !== {1'b1, 32'h11, 1'b1, 32'h22}) begin
      errors++; $display("[TB] FAIL dual_read_rsp: r0=%b/%h r1=%b/%h want 1/11 1/22",
                         r0_rsp_valid, r0_rsp_rdata, r1_rsp_valid, r1_rsp_rdata);
    end
    tick();
    #2;
    checks++;
    if ({r0_rsp_valid, r1_rsp_valid, r0_rsp_rdata} !== {2'b00, 32'h11}) begin
      errors++; $display("[TB] FAIL rsp_hold: valid=%b%b data0=%h want 00 11", r0_rsp_valid, r1_rsp_valid, r0_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_two_writes();
    int startCount;
    doReset();
    startCount = writeCount;
    r0_req_valid = 1; r0_req_we = 1; r0_req_addr = 10'h100; r0_req_wdata = 32'hA0;
    r1_req_valid = 1; r1_req_we = 1; r1_req_addr = 10'h200; r1_req_wdata = 32'hB0;
    #2;
    checks++;
    if ({r0_req_ready, r1_req_ready, mem_addr0, mem_din0} !== {2'b10, 10'h100, 32'hA0}) begin
      errors++; $display("[TB] FAIL ww_grant0: rdy=%b%b a0=%h d0=%h want 10 100 a0", r0_req_ready, r1_req_ready, mem_addr0, mem_din0);
    end
    tick();
    r0_req_addr = 10'h101; r0_req_wdata = 32'hA1;
    #2;
    checks++;
    if ({r0_req_ready, r1_req_ready, mem_addr0, mem_din0} !== {2'b01, 10'h200, 32'hB0}) begin
      errors++; $display("[TB] FAIL ww_grant1: rdy=%b%b a0=%h d0=%h want 01 200 b0", r0_req_ready, r1_req_ready, mem_addr0, mem_din0);
    end
    tick();
    r1_req_addr = 10'h201; r1_req_wdata = 32'hB1;
    #2;
    checks++;
    if ({r0_req_ready, r1_req_ready, mem_addr0, mem_din0} !== {2'b10, 10'h101, 32'hA1}) begin
      errors++; $display("[TB] FAIL ww_grant2: rdy=%b%b a0=%h d0=%h want 10 101 a1", r0_req_ready, r1_req_ready, mem_addr0, mem_din0);
    end
    tick();
    idleInputs();
    tick();
    tick();
    checks++;
    if (writeCount - startCount !== 3) begin
      errors++; $display("[TB] FAIL ww_count: writes=%0d want 3", writeCount - startCount);
    end
    checks++;
    if ({mem[10'h100], mem[10'h200], mem[10'h101]} !== {32'hA0, 32'hB0, 32'hA1}) begin
      errors++; $display("[TB] FAIL ww_contents: %h %h %h want a0 b0 a1", mem[10'h100], mem[10'h200], mem[10'h101]);
    end
  endtask

  task automatic test_hazard();
    doReset();
    dutWrite(10'h3FF, 32'h0BAD_0001);
    r0_req_valid = 1; r0_req_we = 1; r0_req_addr = 10'h3FF; r0_req_wdata = 32'hC0DE_0002;
    r1_req_valid = 1; r1_req_we = 0; r1_req_addr = 10'h3FF;
    #2;
    checks++;
    if ({r0_req_ready, r1_req_ready, mem_csb0, mem_web0, mem_csb1} !== 5'b10001) begin
      errors++; $display("[TB] FAIL hz_writer_first: rdy=%b%b csb0=%b web0=%b csb1=%b want 10 0 0 1",
                         r0_req_ready, r1_req_ready, mem_csb0, mem_web0, mem_csb1);
    end
    tick();
    r0_req_valid = 0; r0_req_we = 0;
    #2;
    checks++;
    if ({r1_req_ready, mem_csb1, mem_addr1} !== {2'b10, 10'h3FF}) begin
      errors++; $display("[TB] FAIL hz_reader_next: rdy=%b csb1=%b a1=%h want 1 0 3ff", r1_req_ready, mem_csb1, mem_addr1);
    end
    tick();
    r1_req_valid = 0;
    tick();
    #2;
    checks++;
    if ({r1_rsp_valid, r1_rsp_rdata} !== {1'b1, 32'hC0DE_0002}) begin
      errors++; $display("[TB] FAIL hz_new_data: valid=%b data=%h want 1 c0de0002", r1_rsp_valid, r1_rsp_rdata);
    end
    tick();
    r0_req_valid = 1; r0_req_we = 1; r0_req_addr = 10'h3FF; r0_req_wdata = 32'hFEED_0003;
    r1_req_valid = 1; r1_req_we = 0; r1_req_addr = 10'h3FF;
    #2;
    checks++;
    if ({r0_req_ready, r1_req_ready, mem_csb0, mem_csb1} !== 4'b0110) begin
      errors++; $display("[TB] FAIL hz_reader_first: rdy=%b%b csb0=%b csb1=%b want 01 1 0",
                         r0_req_ready, r1_req_ready, mem_csb0, mem_csb1);
    end
    tick();
    r1_req_valid = 0;
    #2;
    checks++;
    if ({r0_req_ready, mem_csb0, mem_web0} !== 3'b100) begin
      errors++; $display("[TB] FAIL hz_writer_next: rdy=%b csb0=%b web0=%b want 1 0 0", r0_req_ready, mem_csb0, mem_web0);
    end
    tick();
    idleInputs();
    #2;
    checks++;
    if ({r1_rsp_valid, r1_rsp_rdata} !== {1'b1, 32'hC0DE_0002}) begin
      errors++; $display("[TB] FAIL hz_old_data: valid=%b data=%h want 1 c0de0002", r1_rsp_valid, r1_rsp_rdata);
    end
    tick();
    tick();
    checks++;
    if (mem[10'h3FF] !== 32'hFEED_0003) begin
      errors++; $display("[TB] FAIL hz_final_word: mem=%h want feed0003", mem[10'h3FF]);
    end
  endtask

  task automatic test_reset_mid();
    logic        expValid;
    logic [31:0] expData;
    doReset();
    for (int i = 0; i < 8; i++) dutWrite(10'h040 + 10'(i), 32'h1000 + 32'(i));
    tick();
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        checks++;
        if ({r0_rsp_valid, r0_rsp_rdata} !== {1'b1, 32'h1002}) begin
          errors++; $display("[TB] FAIL mid_pre_reset: valid=%b data=%h want 1 1002", r0_rsp_valid, r0_rsp_rdata);
        end
        r0_req_valid = 0;
        rst_n = 0;
        #1;
        checks++;
        if ({r0_rsp_valid, r0_rsp_rdata, r0_req_ready, mem_csb1} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
          errors++; $display("[TB] FAIL mid_in_reset: valid=%b data=%h rdy=%b csb1=%b want 0 0 0 1",
                             r0_rsp_valid, r0_rsp_rdata, r0_req_ready, mem_csb1);
        end
        #1;
        rst_n = 1;
      end else begin
        r0_req_valid = (c < 8);
        r0_req_we = 0;
        r0_req_addr = 10'h040 + 10'(c);
        #2;
        expValid = (c == 2) || (c == 3) || (c >= 7);
        expData = 32'h1000 + 32'(c - 2);
        checks++;
        if (r0_rsp_valid !== expValid || (expValid && r0_rsp_rdata !== expData)) begin
          errors++; $display("[TB] FAIL mid_cycle%0d: valid=%b data=%h want %b %h", c, r0_rsp_valid, r0_rsp_rdata, expValid, expData);
        end
      end
      tick();
    end
    idleInputs();
  endtask

  initial begin
    idleInputs();
    rst_n = 0;
    #3;
    test_reset();
    test_write_read();
    test_two_reads();
    test_two_writes();
    test_hazard();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
